// File: rtl/game_pkg.sv
// Shared game constants (screen geometry, default hit window, spawn tuning)
// and small helpers used across the game pipeline.
package game_pkg;

    localparam int SCREEN_W     = 640;
    localparam int SCREEN_H     = 480;
    localparam int SCREEN_Y_MAX = SCREEN_H;

    localparam int          DEF_HIT_LO          = 440;
    localparam int          DEF_HIT_HI          = 479;
    localparam logic [15:0] DEF_SPAWN_THRESHOLD = 16'h8000;
    localparam int          DEF_MIN_GAP         = 32;

    localparam int SPEED_W = 20;
    localparam int RAND_W  = 16;

    // Result of the per-column hit search; idx covers up to 16 slots.
    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } hit_sel_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] base, input logic [7:0] inc);
        logic [16:0] sum;
        sum = {1'b0, base} + {9'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/note_lane_manager_if.sv
// Control/status bundle between the game controller and the note lane manager.
interface note_lane_manager_if #(
    parameter int NUM_SLOTS = 8,
    parameter int NUM_COLS  = 4,
    parameter int Y_W       = 10,
    parameter int COL_W     = game_pkg::clog2(NUM_COLS)
);
    logic                       start_i;
    logic [19:0]                speed_i;
    logic [15:0]                rand_i;
    logic [NUM_COLS-1:0]        press_i;
    logic [NUM_SLOTS-1:0]       slot_active_o;
    logic [NUM_SLOTS*COL_W-1:0] slot_col_o;
    logic [NUM_SLOTS*Y_W-1:0]   slot_y_o;
    logic [NUM_COLS-1:0]        hit_pulse_o;
    logic                       miss_pulse_o;
    logic [15:0]                hit_count_o;
    logic [15:0]                miss_count_o;

    modport master (
        output start_i, speed_i, rand_i, press_i,
        input  slot_active_o, slot_col_o, slot_y_o, hit_pulse_o, miss_pulse_o,
               hit_count_o, miss_count_o
    );

    modport slave (
        input  start_i, speed_i, rand_i, press_i,
        output slot_active_o, slot_col_o, slot_y_o, hit_pulse_o, miss_pulse_o,
               hit_count_o, miss_count_o
    );
endinterface

// File: rtl/note_tick_gen.sv
// Programmable tick generator: one tick every (period_i + 1) enabled cycles.
module note_tick_gen #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o
);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // A counter already past a freshly lowered period ticks at once.
    assign tick_o = en_i && (cnt_q >= period_i);

    // Next counter value: wrap on tick, hold when disabled.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/note_lane_manager.sv
// Multi-slot falling-note tracker: spawns notes from a random source, advances
// them on a programmable tick and judges column presses against a hit window.
module note_lane_manager
    import game_pkg::*;
#(
    parameter int          NUM_SLOTS       = 8,
    parameter int          NUM_COLS        = 4,
    parameter int          Y_W             = 10,
    parameter int          Y_MAX           = SCREEN_Y_MAX,
    parameter int          HIT_LO          = DEF_HIT_LO,
    parameter int          HIT_HI          = DEF_HIT_HI,
    parameter int          STEP            = 1,
    parameter logic [15:0] SPAWN_THRESHOLD = DEF_SPAWN_THRESHOLD,
    parameter int          MIN_GAP         = DEF_MIN_GAP
) (
    input  logic               clk,
    input  logic               rst,
    note_lane_manager_if.slave bus
);
    localparam int COL_W = clog2(NUM_COLS);

    localparam logic [Y_W-1:0] HIT_LO_Y  = Y_W'(HIT_LO);
    localparam logic [Y_W-1:0] HIT_HI_Y  = Y_W'(HIT_HI);
    localparam logic [Y_W-1:0] STEP_Y    = Y_W'(STEP);
    localparam logic [Y_W:0]   STEP_X    = (Y_W+1)'(STEP);
    localparam logic [Y_W:0]   Y_MAX_X   = (Y_W+1)'(Y_MAX);
    localparam logic [15:0]    MIN_GAP_G = 16'(MIN_GAP);

    logic [NUM_SLOTS-1:0]            act_q, act_d;
    logic [NUM_SLOTS-1:0][COL_W-1:0] col_q, col_d;
    logic [NUM_SLOTS-1:0][Y_W-1:0]   y_q, y_d;
    logic [15:0]                     gap_q, gap_d;
    logic [NUM_COLS-1:0]             hit_pulse_q, hit_pulse_d;
    logic                            miss_pulse_q, miss_pulse_d;
    logic [15:0]                     hit_count_q, hit_count_d;
    logic [15:0]                     miss_count_q, miss_count_d;

    logic                 tick_s;
    hit_sel_t             sel_s;
    logic [NUM_SLOTS-1:0] hit_clr_s;
    logic [7:0]           hit_inc_s;
    logic [7:0]           press_miss_s;
    logic [7:0]           tick_miss_s;
    logic                 spawn_ok_s;
    logic                 placed_s;

    note_tick_gen #(.CNT_W(SPEED_W)) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en_i     (bus.start_i),
        .period_i (bus.speed_i),
        .tick_o   (tick_s)
    );

    // Candidate with the largest y wins; strict '>' keeps the lowest index on ties.
    function automatic hit_sel_t select_hit(
        input logic [NUM_SLOTS-1:0]            act,
        input logic [NUM_SLOTS-1:0][COL_W-1:0] col,
        input logic [NUM_SLOTS-1:0][Y_W-1:0]   y,
        input logic [COL_W-1:0]                lane
    );
        hit_sel_t       sel;
        logic [Y_W-1:0] best_y;
        sel    = '0;
        best_y = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (act[s] && (col[s] == lane) && (y[s] >= HIT_LO_Y) && (y[s] <= HIT_HI_Y)
                && (!sel.found || (y[s] > best_y))) begin
                sel.found = 1'b1;
                sel.idx   = 4'(s);
                best_y    = y[s];
            end
        end
        return sel;
    endfunction

    // Next state: hit judge, then tick advance/miss, then spawn into freed slots.
    always_comb begin
        act_d        = act_q;
        col_d        = col_q;
        y_d          = y_q;
        gap_d        = gap_q;
        hit_pulse_d  = '0;
        miss_pulse_d = 1'b0;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        sel_s        = '0;
        hit_clr_s    = '0;
        hit_inc_s    = 8'd0;
        press_miss_s = 8'd0;
        tick_miss_s  = 8'd0;
        spawn_ok_s   = 1'b0;
        placed_s     = 1'b0;
        if (bus.start_i) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                sel_s = select_hit(act_q, col_q, y_q, COL_W'(c));
                if (bus.press_i[c] && sel_s.found) begin
                    hit_pulse_d[c] = 1'b1;
                    hit_inc_s      = hit_inc_s + 8'd1;
                    for (int s = 0; s < NUM_SLOTS; s++) begin
                        hit_clr_s[s] = hit_clr_s[s] | (sel_s.idx == 4'(s));
                    end
                end else if (bus.press_i[c]) begin
                    press_miss_s = press_miss_s + 8'd1;
                end else begin
                    hit_pulse_d[c] = 1'b0;
                end
            end
            for (int s = 0; s < NUM_SLOTS; s++) begin
                act_d[s] = act_q[s] & ~hit_clr_s[s];
                col_d[s] = hit_clr_s[s] ? '0 : col_q[s];
                y_d[s]   = hit_clr_s[s] ? '0 : y_q[s];
            end
            if (tick_s) begin
                // Sum at Y_W+1 bits so a note near the top of the range cannot wrap.
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (act_d[s] && (({1'b0, y_q[s]} + STEP_X) >= Y_MAX_X)) begin
                        act_d[s]    = 1'b0;
                        col_d[s]    = '0;
                        y_d[s]      = '0;
                        tick_miss_s = tick_miss_s + 8'd1;
                    end else if (act_d[s]) begin
                        y_d[s] = y_q[s] + STEP_Y;
                    end else begin
                        act_d[s] = 1'b0;
                    end
                end
                miss_pulse_d = (tick_miss_s != 8'd0);
                spawn_ok_s   = (bus.rand_i > SPAWN_THRESHOLD) && (gap_q >= MIN_GAP_G);
                for (int s = 0; s < NUM_SLOTS; s++) begin
                    if (spawn_ok_s && !placed_s && !act_d[s]) begin
                        act_d[s] = 1'b1;
                        col_d[s] = bus.rand_i[COL_W-1:0];
                        y_d[s]   = '0;
                        placed_s = 1'b1;
                    end else begin
                        placed_s = placed_s;
                    end
                end
                if (placed_s) begin
                    gap_d = 16'd0;
                end else if (gap_q >= MIN_GAP_G) begin
                    gap_d = MIN_GAP_G;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end else begin
                gap_d = gap_q;
            end
            hit_count_d  = sat_add16(hit_count_q, hit_inc_s);
            miss_count_d = sat_add16(miss_count_q, press_miss_s + tick_miss_s);
        end else begin
            hit_pulse_d = '0;
        end
    end

    // State and output registers; reset leaves the first spawn unblocked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_q        <= '0;
            col_q        <= '0;
            y_q          <= '0;
            gap_q        <= MIN_GAP_G;
            hit_pulse_q  <= '0;
            miss_pulse_q <= 1'b0;
            hit_count_q  <= 16'd0;
            miss_count_q <= 16'd0;
        end else begin
            act_q        <= act_d;
            col_q        <= col_d;
            y_q          <= y_d;
            gap_q        <= gap_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.slot_active_o = act_q;
    assign bus.slot_col_o    = col_q;
    assign bus.slot_y_o      = y_q;
    assign bus.hit_pulse_o   = hit_pulse_q;
    assign bus.miss_pulse_o  = miss_pulse_q;
    assign bus.hit_count_o   = hit_count_q;
    assign bus.miss_count_o  = miss_count_q;
endmodule

// File: tb/tb_note_lane_manager.sv
// Bench for note_lane_manager: directed scenarios plus random traffic against
// an array-based reference model of the lane rules.
module tb_note_lane_manager;
    localparam int NS  = 8;
    localparam int NC  = 4;
    localparam int YW  = 10;
    localparam int GAP = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    note_lane_manager_if #(.NUM_SLOTS(NS), .NUM_COLS(NC), .Y_W(YW)) bus ();
    note_lane_manager dut (.clk(clk), .rst(rst), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: one entry per slot, counters as plain ints.
    bit          m_act [NS];
    int          m_col [NS];
    int          m_y   [NS];
    int          m_hit, m_miss, m_gap, m_tcnt;
    bit [NC-1:0] m_hitp;
    bit          m_missp;

    task automatic model_reset();
        for (int s = 0; s < NS; s++) begin
            m_act[s] = 1'b0; m_col[s] = 0; m_y[s] = 0;
        end
        m_hit = 0; m_miss = 0; m_gap = GAP; m_tcnt = 0; m_hitp = '0; m_missp = 1'b0;
    endtask

    task automatic model_step();
        bit tick, placed;
        int best, nm;
        m_hitp  = '0;
        m_missp = 1'b0;
        if (!bus.start_i) return;
        tick   = (m_tcnt >= int'(bus.speed_i));
        m_tcnt = tick ? 0 : m_tcnt + 1;
        for (int c = 0; c < NC; c++) begin
            if (bus.press_i[c]) begin
                best = -1;
                for (int s = 0; s < NS; s++)
                    if (m_act[s] && m_col[s] == c && m_y[s] >= 440 && m_y[s] <= 479
                        && (best < 0 || m_y[s] > m_y[best])) best = s;
                if (best >= 0) begin
                    m_act[best] = 1'b0; m_y[best] = 0; m_col[best] = 0;
                    m_hitp[c] = 1'b1;
                    if (m_hit < 65535) m_hit++;
                end else if (m_miss < 65535) m_miss++;
            end
        end
        if (tick) begin
            nm = 0;
            for (int s = 0; s < NS; s++) begin
                if (m_act[s] && m_y[s] + 1 >= 480) begin
                    m_act[s] = 1'b0; m_y[s] = 0; m_col[s] = 0; nm++;
                end else if (m_act[s]) m_y[s]++;
            end
            m_missp = (nm > 0);
            m_miss  = (m_miss + nm > 65535) ? 65535 : m_miss + nm;
            placed  = 1'b0;
            if (int'(bus.rand_i) > 32768 && m_gap >= GAP) begin
                for (int s = 0; s < NS; s++) begin
                    if (!placed && !m_act[s]) begin
                        m_act[s] = 1'b1; m_y[s] = 0; m_col[s] = int'(bus.rand_i) % NC;
                        placed = 1'b1;
                    end
                end
            end
            m_gap = placed ? 0 : ((m_gap + 1 > GAP) ? GAP : m_gap + 1);
        end
    endtask

    function automatic logic [NS-1:0] exp_active();
        logic [NS-1:0] v;
        for (int s = 0; s < NS; s++) v[s] = m_act[s];
        return v;
    endfunction

    function automatic int dut_y(int s);
        return int'(bus.slot_y_o[s*YW +: YW]);
    endfunction

    function automatic int dut_col(int s);
        return int'(bus.slot_col_o[s*2 +: 2]);
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start_i = 1'b0; bus.speed_i = 20'd0; bus.rand_i = 16'd0; bus.press_i = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus.slot_active_o !== 8'h00) begin n_bad++; $display("FAIL reset_active got %h want 00", bus.slot_active_o); end
        n_vec++; if (bus.slot_y_o !== 80'd0) begin n_bad++; $display("FAIL reset_y got %h want 0", bus.slot_y_o); end
        n_vec++; if (bus.hit_count_o !== 16'd0 || bus.miss_count_o !== 16'd0) begin n_bad++; $display("FAIL reset_counts got %0d/%0d want 0/0", bus.hit_count_o, bus.miss_count_o); end
        n_vec++; if (bus.hit_pulse_o !== 4'd0 || bus.miss_pulse_o !== 1'b0) begin n_bad++; $display("FAIL reset_pulses got %b/%b want 0", bus.hit_pulse_o, bus.miss_pulse_o); end
    endtask

    task automatic test_first_spawn();
        do_reset();
        bus.start_i = 1'b1; bus.rand_i = 16'hFFFF;
        cycle();
        n_vec++; if (bus.slot_active_o !== 8'h01) begin n_bad++; $display("FAIL first_spawn_active got %h want 01", bus.slot_active_o); end
        n_vec++; if (dut_col(0) != 3 || dut_y(0) != 0) begin n_bad++; $display("FAIL first_spawn_slot0 got col %0d y %0d want col 3 y 0", dut_col(0), dut_y(0)); end
        for (int i = 0; i < 40 && !m_act[1]; i++) begin
            cycle();
            n_vec++; if (bus.slot_active_o !== exp_active()) begin n_bad++; $display("FAIL gap_active got %h want %h", bus.slot_active_o, exp_active()); end
        end
        n_vec++; if (bus.slot_active_o[1] !== 1'b1 || dut_y(1) != 0) begin n_bad++; $display("FAIL second_spawn got act %b y %0d want 1 0", bus.slot_active_o[1], dut_y(1)); end
        n_vec++; if (dut_y(0) != m_y[0]) begin n_bad++; $display("FAIL second_spawn_y0 got %0d want %0d", dut_y(0), m_y[0]); end
    endtask

    task automatic test_miss();
        do_reset();
        bus.start_i = 1'b1; bus.rand_i = 16'hFFFF;
        cycle();
        bus.rand_i = 16'h0000;
        repeat (479) cycle();
        n_vec++; if (dut_y(0) != 479 || bus.slot_active_o !== 8'h01) begin n_bad++; $display("FAIL miss_pre got y %0d act %h want 479 01", dut_y(0), bus.slot_active_o); end
        cycle();
        n_vec++; if (bus.miss_pulse_o !== 1'b1 || bus.slot_active_o !== 8'h00 || bus.miss_count_o !== 16'd1) begin
            n_bad++; $display("FAIL miss_event got pulse %b act %h cnt %0d want 1 00 1", bus.miss_pulse_o, bus.slot_active_o, bus.miss_count_o); end
        cycle();
        n_vec++; if (bus.miss_pulse_o !== 1'b0) begin n_bad++; $display("FAIL miss_pulse_width got %b want 0", bus.miss_pulse_o); end
    endtask

    task automatic test_hit();
        do_reset();
        bus.start_i = 1'b1; bus.rand_i = 16'hFFFE;
        cycle();
        bus.rand_i = 16'h0000;
        repeat (450) cycle();
        bus.press_i = 4'b0100;
        cycle();
        bus.press_i = 4'b0000;
        n_vec++; if (bus.hit_pulse_o !== 4'b0100 || bus.slot_active_o !== 8'h00) begin n_bad++; $display("FAIL hit_event got pulse %b act %h want 0100 00", bus.hit_pulse_o, bus.slot_active_o); end
        n_vec++; if (bus.hit_count_o !== 16'd1 || bus.miss_count_o !== 16'd0) begin n_bad++; $display("FAIL hit_counts got %0d/%0d want 1/0", bus.hit_count_o, bus.miss_count_o); end
        cycle();
        n_vec++; if (bus.hit_pulse_o !== 4'b0000) begin n_bad++; $display("FAIL hit_pulse_width got %b want 0000", bus.hit_pulse_o); end
        bus.rand_i = 16'hFFFE;
        cycle();
        bus.rand_i = 16'h0000;
        repeat (300) cycle();
        bus.press_i = 4'b0100;
        cycle();
        bus.press_i = 4'b0000;
        n_vec++; if (bus.hit_pulse_o !== 4'b0000 || bus.slot_active_o !== 8'h01 || dut_y(0) != 301) begin
            n_bad++; $display("FAIL early_press got pulse %b act %h y %0d want 0000 01 301", bus.hit_pulse_o, bus.slot_active_o, dut_y(0)); end
        n_vec++; if (bus.miss_count_o !== 16'd1 || bus.hit_count_o !== 16'd1) begin n_bad++; $display("FAIL early_press_counts got %0d/%0d want 1/1", bus.hit_count_o, bus.miss_count_o); end
    endtask

    task automatic test_priority();
        do_reset();
        bus.start_i = 1'b1; bus.rand_i = 16'hFFFD;
        cycle();
        for (int i = 0; i < 40 && !bus.slot_active_o[1]; i++) cycle();
        bus.rand_i = 16'h0000;
        n_vec++; if (bus.slot_active_o !== 8'h03 || dut_col(1) != 1) begin n_bad++; $display("FAIL prio_setup got act %h col %0d want 03 1", bus.slot_active_o, dut_col(1)); end
        for (int i = 0; i < 500 && m_y[0] != 479; i++) cycle();
        n_vec++; if (dut_y(0) != 479) begin n_bad++; $display("FAIL prio_edge_y got %0d want 479", dut_y(0)); end
        bus.press_i = 4'b0010;
        cycle();
        bus.press_i = 4'b0000;
        n_vec++; if (bus.hit_pulse_o !== 4'b0010 || bus.miss_pulse_o !== 1'b0) begin n_bad++; $display("FAIL prio_hit_not_miss got hit %b miss %b want 0010 0", bus.hit_pulse_o, bus.miss_pulse_o); end
        n_vec++; if (bus.slot_active_o !== 8'h02 || dut_y(1) != m_y[1]) begin n_bad++; $display("FAIL prio_survivor got act %h y1 %0d want 02 %0d", bus.slot_active_o, dut_y(1), m_y[1]); end
        n_vec++; if (bus.hit_count_o !== 16'd1 || bus.miss_count_o !== 16'd0) begin n_bad++; $display("FAIL prio_counts got %0d/%0d want 1/0", bus.hit_count_o, bus.miss_count_o); end
    endtask

    task automatic test_fill_and_reset();
        do_reset();
        bus.start_i = 1'b1; bus.rand_i = 16'hFFFF;
        for (int i = 0; i < 300; i++) begin
            cycle();
            n_vec++; if (bus.slot_active_o !== exp_active()) begin n_bad++; $display("FAIL fill_active got %h want %h", bus.slot_active_o, exp_active()); end
        end
        n_vec++; if (bus.slot_active_o !== 8'hFF || dut_y(0) != 299) begin n_bad++; $display("FAIL fill_full got act %h y0 %0d want FF 299", bus.slot_active_o, dut_y(0)); end
        for (int i = 0; i < 200 && m_y[0] != 440; i++) cycle();
        bus.press_i = 4'b1000;
        cycle();
        bus.press_i = 4'b0000;
        n_vec++; if (bus.hit_pulse_o !== 4'b1000 || bus.slot_active_o !== 8'hFF) begin n_bad++; $display("FAIL respawn_hit got pulse %b act %h want 1000 FF", bus.hit_pulse_o, bus.slot_active_o); end
        n_vec++; if (dut_y(0) != 0 || dut_col(0) != 3 || bus.hit_count_o !== 16'd1) begin
            n_bad++; $display("FAIL respawn_slot got y %0d col %0d hits %0d want 0 3 1", dut_y(0), dut_col(0), bus.hit_count_o); end
        #2;
        rst = 1'b1;
        #1;
        n_vec++; if (bus.slot_active_o !== 8'h00 || bus.slot_y_o !== 80'd0 || bus.slot_col_o !== 16'd0) begin
            n_bad++; $display("FAIL async_rst_slots got act %h want 00", bus.slot_active_o); end
        n_vec++; if (bus.hit_count_o !== 16'd0 || bus.miss_count_o !== 16'd0 || bus.hit_pulse_o !== 4'd0) begin
            n_bad++; $display("FAIL async_rst_counts got %0d/%0d want 0/0", bus.hit_count_o, bus.miss_count_o); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_freeze();
        do_reset();
        bus.start_i = 1'b1; bus.rand_i = 16'hFFFF;
        repeat (100) cycle();
        bus.start_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.press_i = 4'($urandom); bus.rand_i = 16'($urandom);
            cycle();
            n_vec++; if (bus.slot_active_o !== exp_active() || dut_y(0) != m_y[0]) begin
                n_bad++; $display("FAIL freeze_state got act %h y0 %0d want %h %0d", bus.slot_active_o, dut_y(0), exp_active(), m_y[0]); end
            n_vec++; if (bus.hit_pulse_o !== 4'd0 || bus.miss_count_o !== 16'd0) begin
                n_bad++; $display("FAIL freeze_press got pulse %b miss %0d want 0 0", bus.hit_pulse_o, bus.miss_count_o); end
        end
        bus.press_i = 4'b0000; bus.start_i = 1'b1;
        cycle();
        n_vec++; if (dut_y(0) != m_y[0]) begin n_bad++; $display("FAIL unfreeze_y got %0d want %0d", dut_y(0), m_y[0]); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) bus.speed_i = 20'($urandom_range(0, 1));
            bus.start_i = ($urandom_range(0, 19) != 0);
            bus.rand_i  = 16'($urandom);
            bus.press_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
            cycle();
            n_vec++; if (bus.slot_active_o !== exp_active()) begin n_bad++; $display("FAIL rnd_active cyc %0d got %h want %h", i, bus.slot_active_o, exp_active()); end
            for (int s = 0; s < NS; s++) begin
                if (m_act[s]) begin
                    n_vec++; if (dut_y(s) != m_y[s] || dut_col(s) != m_col[s]) begin
                        n_bad++; $display("FAIL rnd_slot%0d cyc %0d got y %0d col %0d want y %0d col %0d", s, i, dut_y(s), dut_col(s), m_y[s], m_col[s]); end
                end
            end
            n_vec++; if (bus.hit_pulse_o !== m_hitp || bus.miss_pulse_o !== m_missp) begin
                n_bad++; $display("FAIL rnd_pulses cyc %0d got %b/%b want %b/%b", i, bus.hit_pulse_o, bus.miss_pulse_o, m_hitp, m_missp); end
            n_vec++; if (int'(bus.hit_count_o) != m_hit || int'(bus.miss_count_o) != m_miss) begin
                n_bad++; $display("FAIL rnd_counts cyc %0d got %0d/%0d want %0d/%0d", i, bus.hit_count_o, bus.miss_count_o, m_hit, m_miss); end
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_miss();
        test_hit();
        test_priority();
        test_fill_and_reset();
        test_freeze();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
